axil_reg_bank: RTL and testbench

Generic, parametrised AXI4-Lite register bank. It replaces the fixed-map control register block in front of the AXI4 manager and is reusable by any IP that needs a CPU-visible control/status map. The number of registers and each register's access type (RW, RO, pulse, sticky W1C) are set by parameters. It supports byte strobes, error responses and a stable R channel under backpressure.

---
 rtl/axil_reg_bank_if.sv | 42 ++++
 rtl/axil_reg_bank.sv | 247 ++++++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle for axil_reg_bank: AW, W, B, AR and R channels.
// The master modport is the CPU/interconnect side, slave is the register bank.
interface axil_reg_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;

    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axil_reg_bank.sv
// Parametrised AXI4-Lite register bank with RW, RO, pulse and sticky W1C registers.
// Optional build macro AXIL_REG_PROT_EN: unprivileged (prot[0]=0) accesses to
// non-RO registers get SLVERR; without it the prot fields are ignored.
//
// Write FSM
//   state       | meaning
//   WR_IDLE     | AW and W both ready, nothing held
//   WR_HAVE_AW  | address held, waiting for W
//   WR_HAVE_W   | data held, waiting for AW
//   WR_RESP     | update done, B valid until b_ready
// Read FSM
//   RD_IDLE     | ar_ready high
//   RD_RESP     | R valid, data frozen until r_ready
module axil_reg_bank #(
    parameter int                                     AXIL_ADDR_WIDTH = 32,
    parameter int                                     AXIL_DATA_WIDTH = 32,
    parameter logic [AXIL_ADDR_WIDTH-1:0]             BASE_ADDR       = '0,
    parameter int                                     REG_COUNT       = 16,
    parameter logic [REG_COUNT-1:0]                   RO_MASK         = '0,
    parameter logic [REG_COUNT-1:0]                   PULSE_MASK      = '0,
    parameter logic [REG_COUNT-1:0]                   STICKY_MASK     = '0,
    parameter logic [REG_COUNT*AXIL_DATA_WIDTH-1:0]   RESET_VALUES    = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    axil_reg_bank_if.slave                       bus,
    output logic [REG_COUNT*AXIL_DATA_WIDTH-1:0] reg_o,
    output logic [REG_COUNT-1:0]                 wr_stb_o,
    input  logic [REG_COUNT*AXIL_DATA_WIDTH-1:0] hw_data_i,
    input  logic [REG_COUNT*AXIL_DATA_WIDTH-1:0] hw_set_i
);
    localparam int AW       = AXIL_ADDR_WIDTH;
    localparam int DW       = AXIL_DATA_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    function automatic logic addr_hit(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return (off[ADDR_LSB-1:0] == '0) && ((off >> ADDR_LSB) < AW'(REG_COUNT));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> ADDR_LSB);
    endfunction

    logic [DW-1:0]     regs [REG_COUNT];
    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic [AW-1:0]     aw_addr_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data, wr_mask;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_hit, wr_ro, wr_priv_err, wr_err, wr_apply;
    logic              rd_hit, rd_ro, rd_priv_err, rd_err;
    logic [DW-1:0]     rd_value;
    logic [REG_COUNT-1:0] wr_sel;

`ifdef AXIL_REG_PROT_EN
    logic              aw_prot0_q;
    logic              wr_prot0;
`else
    logic              unused_prot;
    assign unused_prot = ^{bus.aw_prot, bus.ar_prot};
`endif

    logic unused_hw;
    assign unused_hw = ^{hw_data_i, hw_set_i};

    // Write-side decode: the address/data come from the bus when the handshake
    // is happening now, otherwise from the holding registers.
    always_comb begin
        aw_hs     = bus.aw_valid && bus.aw_ready;
        w_hs      = bus.w_valid && bus.w_ready;
        wr_commit = (wr_state != WR_RESP)
                 && (aw_hs || (wr_state == WR_HAVE_AW))
                 && (w_hs  || (wr_state == WR_HAVE_W));
        wr_addr   = aw_hs ? bus.aw_addr : aw_addr_q;
        wr_data   = w_hs  ? bus.w_data  : w_data_q;
        wr_strb   = w_hs  ? bus.w_strb  : w_strb_q;
        for (int b = 0; b < STRB_W; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
        end
        wr_hit = addr_hit(wr_addr);
        wr_idx = addr_idx(wr_addr);
        wr_ro  = wr_hit && RO_MASK[wr_idx];
`ifdef AXIL_REG_PROT_EN
        wr_prot0    = aw_hs ? bus.aw_prot[0] : aw_prot0_q;
        wr_priv_err = wr_hit && !wr_ro && !wr_prot0;
`else
        wr_priv_err = 1'b0;
`endif
        wr_err   = !wr_hit || wr_priv_err;
        wr_apply = wr_commit && wr_hit && !wr_ro && !wr_priv_err;
        wr_sel   = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            wr_sel[i] = wr_apply && (wr_idx == IDX_W'(i));
        end
    end

    // Read-side decode; RO registers return the live hardware value.
    always_comb begin
        ar_hs  = bus.ar_valid && bus.ar_ready;
        rd_hit = addr_hit(bus.ar_addr);
        rd_idx = addr_idx(bus.ar_addr);
        rd_ro  = rd_hit && RO_MASK[rd_idx];
`ifdef AXIL_REG_PROT_EN
        rd_priv_err = rd_hit && !rd_ro && !bus.ar_prot[0];
`else
        rd_priv_err = 1'b0;
`endif
        rd_err   = !rd_hit || rd_priv_err;
        rd_value = '0;
        if (!rd_err) begin
            rd_value = rd_ro ? hw_data_i[int'(rd_idx)*DW +: DW] : regs[rd_idx];
        end
    end

    // Register storage: per-register behaviour selected by the type masks.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= (RO_MASK[i] || PULSE_MASK[i] || STICKY_MASK[i])
                         ? '0 : RESET_VALUES[i*DW +: DW];
            end
            wr_stb_o <= '0;
        end else begin
            wr_stb_o <= wr_sel;
            for (int i = 0; i < REG_COUNT; i++) begin
                if (RO_MASK[i]) begin
                    regs[i] <= hw_data_i[i*DW +: DW];
                end else if (STICKY_MASK[i]) begin
                    regs[i] <= (regs[i] & ~(wr_sel[i] ? (wr_data & wr_mask) : '0))
                             | hw_set_i[i*DW +: DW];
                end else if (PULSE_MASK[i]) begin
                    regs[i] <= wr_sel[i] ? (wr_data & wr_mask) : '0;
                end else if (wr_sel[i]) begin
                    regs[i] <= (regs[i] & ~wr_mask) | (wr_data & wr_mask);
                end
            end
        end
    end

    // Flatten the register array, register 0 in the LSBs.
    always_comb begin
        reg_o = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_o[i*DW +: DW] = regs[i];
        end
    end

    // Write FSM: independent AW/W capture, commit, then hold B until accepted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state     <= WR_IDLE;
            bus.aw_ready <= 1'b1;
            bus.w_ready  <= 1'b1;
            bus.b_valid  <= 1'b0;
            bus.b_resp   <= RESP_OKAY;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
`ifdef AXIL_REG_PROT_EN
            aw_prot0_q   <= 1'b0;
`endif
        end else begin
            if (aw_hs) begin
                aw_addr_q    <= bus.aw_addr;
`ifdef AXIL_REG_PROT_EN
                aw_prot0_q   <= bus.aw_prot[0];
`endif
                bus.aw_ready <= 1'b0;
            end
            if (w_hs) begin
                w_data_q    <= bus.w_data;
                w_strb_q    <= bus.w_strb;
                bus.w_ready <= 1'b0;
            end
            if (wr_commit) begin
                wr_state    <= WR_RESP;
                bus.b_valid <= 1'b1;
                bus.b_resp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                case (wr_state)
                    WR_IDLE: begin
                        if (aw_hs)     wr_state <= WR_HAVE_AW;
                        else if (w_hs) wr_state <= WR_HAVE_W;
                    end
                    WR_RESP: begin
                        if (bus.b_ready) begin
                            wr_state     <= WR_IDLE;
                            bus.b_valid  <= 1'b0;
                            bus.aw_ready <= 1'b1;
                            bus.w_ready  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read FSM: register data on AR, keep it frozen until the R handshake.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_state     <= RD_IDLE;
            bus.ar_ready <= 1'b1;
            bus.r_valid  <= 1'b0;
            bus.r_data   <= '0;
            bus.r_resp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state     <= RD_RESP;
                        bus.ar_ready <= 1'b0;
                        bus.r_valid  <= 1'b1;
                        bus.r_data   <= rd_value;
                        bus.r_resp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                RD_RESP: begin
                    if (bus.r_ready) begin
                        rd_state     <= RD_IDLE;
                        bus.r_valid  <= 1'b0;
                        bus.ar_ready <= 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: 8 registers at 0x100.
// reg0 RO, reg1/2/5/6/7 RW (reg5 resets to 0x12345678), reg3 sticky, reg4 pulse.
module tb_axil_reg_bank;
    localparam int RC = 8;
    localparam logic [RC*32-1:0] RST_IMG =
        {32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b1;
    always #5 clk_i = ~clk_i;

    axil_reg_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    logic [RC*32-1:0] reg_o, hw_data_i, hw_set_i;
    logic [RC-1:0]    wr_stb_o;
    logic [2:0]       prot;

    axil_reg_bank #(
        .AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .BASE_ADDR(32'h100),
        .REG_COUNT(RC), .RO_MASK(8'h01), .PULSE_MASK(8'h10),
        .STICKY_MASK(8'h08), .RESET_VALUES(RST_IMG)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus), .reg_o(reg_o),
        .wr_stb_o(wr_stb_o), .hw_data_i(hw_data_i), .hw_set_i(hw_set_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rv(input int i);
        return reg_o[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        logic found = 1'b0;
        resp = 2'bxx;
        bus.b_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (bus.b_valid) begin
                found = 1'b1;
                resp  = bus.b_resp;
                break;
            end
        end
        if (!found) check("b_timeout", 0, 1);
        tick();
        bus.b_ready = 1'b0;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.aw_addr = addr; bus.aw_prot = prot; bus.aw_valid = 1'b1;
        bus.w_data  = data; bus.w_strb  = strb; bus.w_valid  = 1'b1;
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp);
        logic ad = 1'b0, wd = 1'b0, a, w;
        start_write(addr, data, strb);
        for (int n = 0; n < 20 && !(ad && wd); n++) begin
            @(negedge clk_i);
            a = bus.aw_valid && bus.aw_ready;
            w = bus.w_valid && bus.w_ready;
            tick();
            if (a) begin bus.aw_valid = 1'b0; ad = 1'b1; end
            if (w) begin bus.w_valid  = 1'b0; wd = 1'b1; end
        end
        if (!(ad && wd)) check("wr_hs_timeout", 0, 1);
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        wait_b(resp);
    endtask

    task automatic read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic done = 1'b0, found = 1'b0;
        data = 'x; resp = 'x;
        bus.ar_addr = addr; bus.ar_prot = prot; bus.ar_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk_i);
            done = bus.ar_ready;
            tick();
        end
        bus.ar_valid = 1'b0;
        if (!done) check("ar_timeout", 0, 1);
        bus.r_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (bus.r_valid) begin
                found = 1'b1; data = bus.r_data; resp = bus.r_resp;
                break;
            end
        end
        if (!found) check("r_timeout", 0, 1);
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        bus.aw_valid = 0; bus.w_valid = 0; bus.b_ready = 0; bus.ar_valid = 0; bus.r_ready = 0;
        bus.aw_addr = 0; bus.w_data = 0; bus.w_strb = 0; bus.ar_addr = 0;
        bus.aw_prot = 0; bus.ar_prot = 0;
        prot = 3'b001;
        hw_set_i  = '0;
        hw_data_i = '0;
        hw_data_i[31:0] = 32'hA5A50001;

        #1 rstn_i = 1'b0;
        #2;
        check("rst_aw_ready", bus.aw_ready, 1);
        check("rst_w_ready",  bus.w_ready, 1);
        check("rst_ar_ready", bus.ar_ready, 1);
        check("rst_b_valid",  bus.b_valid, 0);
        check("rst_r_valid",  bus.r_valid, 0);
        check("rst_b_resp",   bus.b_resp, 0);
        check("rst_r_resp",   bus.r_resp, 0);
        check("rst_r_data",   bus.r_data, 0);
        check("rst_wr_stb",   wr_stb_o, 0);
        check("rst_reg5",     rv(5), 32'h12345678);
        check("rst_reg2",     rv(2), 0);
        repeat (2) @(posedge clk_i);
        #2 rstn_i = 1'b1;
        tick();

        // Byte strobes on reg2, same-cycle AW/W
        start_write(32'h108, 32'hDEADBEEF, 4'b0101);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        check("strb_b_valid", bus.b_valid, 1);
        check("strb_b_resp",  bus.b_resp, 0);
        check("strb_wr_stb",  wr_stb_o, 8'h04);
        check("strb_reg2",    rv(2), 32'h00AD00EF);
        bus.b_ready = 1;
        tick();
        bus.b_ready = 0;
        check("strb_wr_stb_off", wr_stb_o, 0);
        check("strb_b_done",     bus.b_valid, 0);
        check("strb_aw_ready",   bus.aw_ready, 1);
        check("strb_w_ready",    bus.w_ready, 1);
        read(32'h108, data, resp);
        check("strb_rd_data", data, 32'h00AD00EF);
        check("strb_rd_resp", resp, 0);

        // W three cycles before AW
        bus.w_data = 32'h5; bus.w_strb = 4'hF; bus.w_valid = 1;
        tick();
        bus.w_valid = 0;
        check("wfirst_w_ready", bus.w_ready, 0);
        check("wfirst_aw_ready", bus.aw_ready, 1);
        repeat (2) tick();
        check("wfirst_no_b", bus.b_valid, 0);
        bus.aw_addr = 32'h104; bus.aw_prot = prot; bus.aw_valid = 1;
        tick();
        bus.aw_valid = 0;
        check("wfirst_b_lat", bus.b_valid, 1);
        check("wfirst_reg1",  rv(1), 32'h5);
        wait_b(resp);
        check("wfirst_resp", resp, 0);

        // AW three cycles before W
        bus.aw_addr = 32'h104; bus.aw_prot = prot; bus.aw_valid = 1;
        tick();
        bus.aw_valid = 0;
        check("awfirst_aw_ready", bus.aw_ready, 0);
        repeat (2) tick();
        check("awfirst_no_b", bus.b_valid, 0);
        bus.w_data = 32'h6; bus.w_strb = 4'hF; bus.w_valid = 1;
        tick();
        bus.w_valid = 0;
        check("awfirst_b_lat", bus.b_valid, 1);
        check("awfirst_reg1",  rv(1), 32'h6);
        wait_b(resp);

        write(32'h104, 32'h7, 4'hF, resp);
        check("same_resp", resp, 0);
        check("same_reg1", rv(1), 32'h7);

        // Read of RO reg0 under R backpressure while hw_data changes
        bus.ar_addr = 32'h100; bus.ar_prot = prot; bus.ar_valid = 1;
        tick();
        bus.ar_valid = 0;
        check("stall_r_valid", bus.r_valid, 1);
        for (int k = 0; k < 4; k++) begin
            hw_data_i[31:0] = 32'h100 + k;
            tick();
            check("stall_r_data", bus.r_data, 32'hA5A50001);
            check("stall_ar_ready", bus.ar_ready, 0);
        end
        bus.r_ready = 1;
        tick();
        bus.r_ready = 0;
        check("stall_r_done", bus.r_valid, 0);
        check("stall_ar_back", bus.ar_ready, 1);
        check("ro_mirror", rv(0), 32'h103);
        write(32'h100, 32'hFFFFFFFF, 4'hF, resp);
        check("ro_wr_resp", resp, 0);
        check("ro_wr_ignored", rv(0), 32'h103);

        // Sticky reg3
        hw_set_i[3*32+4] = 1'b1;
        tick();
        hw_set_i = '0;
        check("sticky_set", rv(3), 32'h10);
        read(32'h10C, data, resp);
        check("sticky_rd", data, 32'h10);
        start_write(32'h10C, 32'h10, 4'hF);
        hw_set_i[3*32+4] = 1'b1;
        tick();
        hw_set_i = '0;
        bus.aw_valid = 0; bus.w_valid = 0;
        check("sticky_set_wins", rv(3), 32'h10);
        wait_b(resp);
        write(32'h10C, 32'h10, 4'hF, resp);
        read(32'h10C, data, resp);
        check("sticky_cleared", data, 32'h0);

        // Pulse reg4
        start_write(32'h110, 32'h0000CAFE, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        check("pulse_value", rv(4), 32'hCAFE);
        check("pulse_stb", wr_stb_o, 8'h10);
        tick();
        check("pulse_clear", rv(4), 32'h0);
        wait_b(resp);

        // Decode errors
        write(32'h120, 32'hFFFFFFFF, 4'hF, resp);
        check("oor_wr_resp", resp, 2'b10);
        check("oor_reg1", rv(1), 32'h7);
        check("oor_reg7", rv(7), 32'h0);
        read(32'h120, data, resp);
        check("oor_rd_resp", resp, 2'b10);
        check("oor_rd_data", data, 0);
        start_write(32'h106, 32'hFFFFFFFF, 4'hF);
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        check("mis_wr_stb", wr_stb_o, 0);
        wait_b(resp);
        check("mis_wr_resp", resp, 2'b10);
        check("mis_reg1", rv(1), 32'h7);
        read(32'h102, data, resp);
        check("mis_rd_resp", resp, 2'b10);
        check("mis_rd_data", data, 0);
        read(32'h0FC, data, resp);
        check("below_rd_resp", resp, 2'b10);

        // Read and write of reg6 in the same cycle
        write(32'h118, 32'h11, 4'hF, resp);
        bus.ar_addr = 32'h118; bus.ar_prot = prot; bus.ar_valid = 1;
        start_write(32'h118, 32'h22, 4'hF);
        tick();
        bus.ar_valid = 0; bus.aw_valid = 0; bus.w_valid = 0;
        check("rw_r_valid", bus.r_valid, 1);
        check("rw_old_data", bus.r_data, 32'h11);
        check("rw_new_reg6", rv(6), 32'h22);
        bus.r_ready = 1;
        tick();
        bus.r_ready = 0;
        wait_b(resp);

`ifdef AXIL_REG_PROT_EN
        prot = 3'b000;
        write(32'h104, 32'h99, 4'hF, resp);
        check("prot_wr_resp", resp, 2'b10);
        check("prot_reg1", rv(1), 32'h7);
        read(32'h104, data, resp);
        check("prot_rd_resp", resp, 2'b10);
        check("prot_rd_data", data, 0);
        read(32'h100, data, resp);
        check("prot_ro_resp", resp, 0);
        prot = 3'b001;
`endif

        // Reset between AW and W
        bus.aw_addr = 32'h104; bus.aw_prot = prot; bus.aw_valid = 1;
        tick();
        bus.aw_valid = 0;
        check("mid_aw_taken", bus.aw_ready, 0);
        #2 rstn_i = 1'b0;
        #1;
        check("mid_aw_ready", bus.aw_ready, 1);
        check("mid_w_ready",  bus.w_ready, 1);
        check("mid_b_valid",  bus.b_valid, 0);
        check("mid_reg1",     rv(1), 0);
        check("mid_reg2",     rv(2), 0);
        check("mid_reg5",     rv(5), 32'h12345678);
        @(posedge clk_i);
        #2 rstn_i = 1'b1;
        tick();
        tick();
        check("mid_no_b", bus.b_valid, 0);
        write(32'h104, 32'h77, 4'hF, resp);
        check("post_rst_resp", resp, 0);
        read(32'h104, data, resp);
        check("post_rst_data", data, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
